// File: rtl/fft32_pkg.sv
// fft32_pkg: shared constants and complex-sample type for the 32-point MDC FFT
package fft32_pkg;
  localparam int FFT_N = 32;
  localparam int FFT_WIDTH = 9;
  localparam int FFT_HALF = FFT_N / 2;
  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;
endpackage

// File: rtl/mdc_half_buffer.sv
// mdc_half_buffer: half-frame register file, synchronous write, combinational read, no reset
import fft32_pkg::*;
module mdc_half_buffer #(
  parameter int DEPTH = FFT_HALF,
  parameter int W = 2 * FFT_WIDTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/mdc_input_commutator.sv
// mdc_input_commutator: splits a natural-order serial stream into x[k] / x[k+N/2] pairs
import fft32_pkg::*;
module mdc_input_commutator #(
  parameter int WIDTH = FFT_WIDTH,
  parameter int N = FFT_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             out_valid,
  output logic             out_sof,
  output logic [WIDTH-1:0] Up_out_re,
  output logic [WIDTH-1:0] Up_out_im,
  output logic [WIDTH-1:0] Low_out_re,
  output logic [WIDTH-1:0] Low_out_im,
  output logic             sync_err
);
  localparam int AW = $clog2(N);
  localparam int HW = AW - 1;
  localparam int DW = 2 * WIDTH;
  logic [AW-1:0] cnt_q, cnt_d, idx;
  logic          out_valid_q, out_valid_d, out_sof_q, out_sof_d, sync_err_q, sync_err_d;
  logic [DW-1:0] up_q, up_d, low_q, low_d, rdata;
  logic          sof, emit;
  always_comb begin
    sof = in_valid & in_sof;
    idx = sof ? '0 : cnt_q;
    emit = in_valid & idx[AW-1];
    cnt_d = in_valid ? idx + AW'(1) : cnt_q;
    out_valid_d = emit;
    out_sof_d = emit & (idx[HW-1:0] == '0);
    up_d = emit ? rdata : up_q;
    low_d = emit ? {in_re, in_im} : low_q;
    sync_err_d = sync_err_q | (sof & (cnt_q != '0));
  end
  // the read slot idx-N/2 shares the low bits of idx, so one address serves both halves
  mdc_half_buffer #(.DEPTH(N / 2), .W(DW)) u_buf (
    .clk  (clk),
    .we   (in_valid & ~idx[AW-1]),
    .waddr(idx[HW-1:0]),
    .wdata({in_re, in_im}),
    .raddr(idx[HW-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_sof_q <= 1'b0;
      up_q <= '0;
      low_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sof_q <= out_sof_d;
      up_q <= up_d;
      low_q <= low_d;
      sync_err_q <= sync_err_d;
    end
  assign out_valid = out_valid_q;
  assign out_sof = out_sof_q;
  assign {Up_out_re, Up_out_im} = up_q;
  assign {Low_out_re, Low_out_im} = low_q;
  assign sync_err = sync_err_q;
endmodule

// File: tb/tb_mdc_input_commutator.sv
// tb_mdc_input_commutator: randomized frame-level checks against a queue-based pairing model
module tb_mdc_input_commutator;
  logic       clk, rst_n, in_valid, in_sof;
  logic [8:0] in_re, in_im;
  logic       out_valid, out_sof, sync_err;
  logic [8:0] Up_out_re, Up_out_im, Low_out_re, Low_out_im;
  logic [38:0] obs;
  int vectors = 0;
  int errors = 0;
  logic [17:0] cur[$];
  logic        exp_valid, exp_sof, exp_err;
  logic [17:0] exp_up, exp_low;

  mdc_input_commutator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_sof(out_sof),
    .Up_out_re(Up_out_re), .Up_out_im(Up_out_im),
    .Low_out_re(Low_out_re), .Low_out_im(Low_out_im), .sync_err(sync_err)
  );

  assign obs = {out_valid, out_sof, sync_err, Up_out_re, Up_out_im, Low_out_re, Low_out_im};

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [38:0] expv();
    return {exp_valid, exp_sof, exp_err, exp_up, exp_low};
  endfunction

  task automatic model_reset();
    cur.delete();
    exp_valid = 0; exp_sof = 0; exp_err = 0; exp_up = '0; exp_low = '0;
  endtask

  // a frame is the list of samples since the last sof; sample k>=N/2 pairs with sample k-N/2
  task automatic step(input logic v, input logic s, input logic [8:0] re, input logic [8:0] im);
    in_valid = v; in_sof = s; in_re = re; in_im = im;
    @(posedge clk); #1;
    exp_valid = 0; exp_sof = 0;
    if (v) begin
      if (s) begin
        if (cur.size() != 0) exp_err = 1;
        cur.delete();
      end
      cur.push_back({re, im});
      if (cur.size() > 16) begin
        exp_valid = 1;
        exp_sof = (cur.size() == 17);
        exp_up = cur[cur.size() - 17];
        exp_low = cur[cur.size() - 1];
      end
      if (cur.size() == 32) cur.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; in_sof = 0; in_re = 0; in_im = 0;
    model_reset();
    #12;
    vectors++;
    if (obs !== 39'd0) begin errors++; $display("FAIL reset_init obs=%h exp=0", obs); end
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 20; k++) step(1, k == 0, 9'(k + 1), 9'(-(k + 1)));
    #3 rst_n = 0;
    model_reset();
    #1;
    vectors++;
    if (obs !== 39'd0) begin errors++; $display("FAIL reset_async obs=%h exp=0", obs); end
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      step(1, k == 0, 9'(k + 7), 9'(k * 3));
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL reset_frame k=%0d obs=%h exp=%h", k, obs, expv()); end
    end
  endtask

  task automatic test_single_frame();
    for (int k = 0; k < 32; k++) begin
      step(1, k == 0, 9'(k), 9'(-k));
      exp_valid = (k >= 16); exp_sof = (k == 16);
      if (k >= 16) begin
        exp_up = {9'(k - 16), 9'(16 - k)};
        exp_low = {9'(k), 9'(-k)};
      end
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL single k=%0d obs=%h exp=%h", k, obs, expv()); end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 64; k++) begin
      step(1, k % 32 == 0, 9'(k % 32 + (k >= 32 ? 100 : 0)), 9'(-(k % 32 + (k >= 32 ? 100 : 0))));
      vectors++;
      if (out_valid !== (k % 32 >= 16)) begin errors++; $display("FAIL b2b_pattern k=%0d obs=%b exp=%b", k, out_valid, k % 32 >= 16); end
      vectors++;
      if (k >= 48 && {Up_out_re, Low_out_re} !== {9'(k - 48 + 100), 9'(k - 32 + 100)}) begin
        errors++; $display("FAIL b2b_data k=%0d obs=%h", k, {Up_out_re, Low_out_re});
      end
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL b2b k=%0d obs=%h exp=%h", k, obs, expv()); end
    end
  endtask

  task automatic test_gaps();
    int k = 0;
    int guard = 0;
    while (k < 96 && guard < 2000) begin
      guard++;
      if ($urandom_range(99) < 40) step(0, 1'($urandom), 9'($urandom), 9'($urandom));
      else begin
        step(1, k % 32 == 0, 9'($urandom), 9'($urandom));
        k++;
      end
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL gaps k=%0d obs=%h exp=%h", k, obs, expv()); end
    end
    vectors++;
    if (k != 96) begin errors++; $display("FAIL gaps_budget obs=%0d exp=96", k); end
  endtask

  task automatic test_resync(input int at);
    for (int k = 0; k < at; k++) begin
      step(1, k == 0, 9'($urandom), 9'($urandom));
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL resync%0d_pre k=%0d obs=%h exp=%h", at, k, obs, expv()); end
    end
    for (int k = 0; k < 32; k++) begin
      step(1, k == 0, 9'($urandom), 9'($urandom));
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL resync%0d k=%0d obs=%h exp=%h", at, k, obs, expv()); end
    end
    vectors++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL resync%0d_err obs=%b exp=1", at, sync_err); end
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 32; k++) begin
      step(1, k == 0, k[0] ? 9'h0ff : 9'h100, k[0] ? 9'h100 : 9'h0ff);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL extremes k=%0d obs=%h exp=%h", k, obs, expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gaps();
    test_resync(10);
    test_resync(24);
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
